// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, defaults and sizing helper for the SIPO receiver
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sipo_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Width of bit_count: it only ever holds 0..WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_word_hold.sv
// rtl/sipo_word_hold.sv - single-entry output register with valid/ready and sticky overflow
module sipo_word_hold
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] word_data,
  input  logic             out_ready,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overflow
);

  logic consume;
  logic can_load;
  logic drop;

  // A word consumed on the same edge frees the slot, so back-to-back words are lossless.
  always_comb begin
    consume  = out_valid & out_ready;
    can_load = ~out_valid | out_ready;
    drop     = word_valid & ~can_load;
  end

  // Output register: load a completed word when the slot is free, else hold the old one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
    end else if (word_valid && can_load) begin
      parallel_out <= word_data;
      out_valid    <= 1'b1;
    end else if (consume) begin
      out_valid    <= 1'b0;
    end
  end

  // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - MSB-first serial-in parallel-out receiver with framing and output hold
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam int CW = cnt_w(WIDTH);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("sipo_deserializer: WIDTH must be in 2..32");
    end
  endgenerate

  sipo_state_t      state;
  sipo_state_t      state_nxt;
  logic [CW-1:0]    bit_count;
  logic [CW-1:0]    bit_count_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_reg_nxt;
  logic [WIDTH-1:0] shifted;
  logic             word_done;

  // State register for the framing FSM, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_count <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      bit_count <= bit_count_nxt;
      shift_reg <= shift_reg_nxt;
    end
  end

  // Next-state logic: frame_start resyncs from any state; gaps hold everything.
  always_comb begin
    state_nxt     = state;
    bit_count_nxt = bit_count;
    shift_reg_nxt = shift_reg;
    word_done     = 1'b0;
    shifted       = {shift_reg[WIDTH-2:0], serial_in};

    if (serial_valid) begin
      if (frame_start) begin
        // Partial word is discarded silently; the new MSB starts a fresh word.
        state_nxt     = ACCUM;
        bit_count_nxt = CW'(1);
        shift_reg_nxt = {{(WIDTH-1){1'b0}}, serial_in};
      end else begin
        shift_reg_nxt = shifted;
        case (state)
          IDLE: begin
            state_nxt     = ACCUM;
            bit_count_nxt = CW'(1);
          end
          ACCUM: begin
            if (bit_count == CW'(WIDTH - 1)) begin
              word_done     = 1'b1;
              state_nxt     = IDLE;
              bit_count_nxt = '0;
            end else begin
              bit_count_nxt = bit_count + CW'(1);
            end
          end
          default: begin
            state_nxt     = IDLE;
            bit_count_nxt = '0;
          end
        endcase
      end
    end
  end

  assign busy = (state == ACCUM);

  sipo_word_hold #(
    .WIDTH(WIDTH)
  ) u_word_hold (
    .clk           (clk),
    .reset         (reset),
    .word_valid    (word_done),
    .word_data     (shifted),
    .out_ready     (out_ready),
    .clear_overflow(clear_overflow),
    .parallel_out  (parallel_out),
    .out_valid     (out_valid),
    .overflow      (overflow)
  );

endmodule
